// File: rtl/predictor_pkg.sv
// Shared definitions for the predictor row-multiply driver: FSM encoding and
// default sizing parameters.
package predictor_pkg;

    localparam int DATA_W_DEF         = 64;
    localparam int TIMEOUT_CYCLES_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT0  = 3'd3,
        ST_OUT1  = 3'd4
    } state_e;

endpackage

// File: rtl/predictor_result_capture.sv
// Holds the two core result words and their received flags; a word that was
// never strobed since the last clear reads back as zero.
module predictor_result_capture #(
    parameter int DATA_W = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [DATA_W-1:0] y0_in,
    input  logic              y0_vld,
    input  logic [DATA_W-1:0] y1_in,
    input  logic              y1_vld,
    output logic [DATA_W-1:0] y0_word,
    output logic [DATA_W-1:0] y1_word
);

    logic [DATA_W-1:0] y0_q, y0_d;
    logic [DATA_W-1:0] y1_q, y1_d;
    logic              y0_rcv_q, y0_rcv_d;
    logic              y1_rcv_q, y1_rcv_d;

    always_comb begin
        y0_d     = y0_q;
        y1_d     = y1_q;
        y0_rcv_d = y0_rcv_q;
        y1_rcv_d = y1_rcv_q;
        if (clear) begin
            y0_rcv_d = 1'b0;
            y1_rcv_d = 1'b0;
        end else if (enable) begin
            if (y0_vld) begin
                y0_d     = y0_in;
                y0_rcv_d = 1'b1;
            end
            if (y1_vld) begin
                y1_d     = y1_in;
                y1_rcv_d = 1'b1;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            y0_q     <= '0;
            y1_q     <= '0;
            y0_rcv_q <= 1'b0;
            y1_rcv_q <= 1'b0;
        end else begin
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            y0_rcv_q <= y0_rcv_d;
            y1_rcv_q <= y1_rcv_d;
        end
    end

    // Missing words are reported as zero rather than stale data.
    assign y0_word = y0_rcv_q ? y0_q : '0;
    assign y1_word = y1_rcv_q ? y1_q : '0;

endmodule

// File: rtl/predictor_mvmult_row_driver.sv
// Drives one sample through an ap_ctrl_hs row-multiply core and streams its two
// result words out, aborting with a sticky error if the core never finishes.
module predictor_mvmult_row_driver
    import predictor_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int DATA_W         = DATA_W_DEF
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic [DATA_W-1:0] x_tdata,
    input  logic              x_tvalid,
    output logic              x_tready,
    output logic              core_ap_start,
    input  logic              core_ap_ready,
    input  logic              core_ap_done,
    input  logic              core_ap_idle,
    output logic [DATA_W-1:0] core_x,
    input  logic [DATA_W-1:0] core_y0,
    input  logic [DATA_W-1:0] core_y1,
    input  logic              core_y0_vld,
    input  logic              core_y1_vld,
    output logic [DATA_W-1:0] y_tdata,
    output logic              y_tvalid,
    input  logic              y_tready,
    output logic              y_tlast,
    output logic              busy,
    output logic              err_timeout,
    input  logic              err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] core_x_q, core_x_d;
    logic              cap_clear, cap_enable, timeout_hit;
    logic [DATA_W-1:0] y0_word, y1_word;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        core_x_d    = core_x_q;
        cap_clear   = 1'b0;
        cap_enable  = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (x_tvalid && !err_q) begin
                    core_x_d  = x_tdata;
                    cnt_d     = '0;
                    cap_clear = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end else if (core_ap_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Strobes in the done cycle still land, so capture is always on here.
                cap_enable = 1'b1;
                cnt_d      = cnt_q + CNT_W'(1);
                if (core_ap_done) begin
                    state_d = ST_OUT0;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_OUT0: begin
                if (y_tready) state_d = ST_OUT1;
            end
            ST_OUT1: begin
                if (y_tready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_q;
        if (err_clr)     err_d = 1'b0;
        if (timeout_hit) err_d = 1'b1;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            core_x_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            core_x_q <= core_x_d;
        end
    end

    predictor_result_capture #(
        .DATA_W (DATA_W)
    ) u_capture (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clear    (cap_clear),
        .enable   (cap_enable),
        .y0_in    (core_y0),
        .y0_vld   (core_y0_vld),
        .y1_in    (core_y1),
        .y1_vld   (core_y1_vld),
        .y0_word  (y0_word),
        .y1_word  (y1_word)
    );

    assign x_tready      = (state_q == ST_IDLE) && !err_q;
    assign core_ap_start = (state_q == ST_START);
    assign core_x        = core_x_q;
    assign y_tvalid      = (state_q == ST_OUT0) || (state_q == ST_OUT1);
    assign y_tlast       = (state_q == ST_OUT1);
    assign y_tdata       = (state_q == ST_OUT1) ? y1_word : y0_word;
    assign busy          = (state_q != ST_IDLE);
    assign err_timeout   = err_q;

    // The core's idle flag carries no control meaning; only sanity-check it.
    a_core_idle_known: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        !$isunknown(core_ap_idle));

endmodule

// File: doc/predictor_mvmult_row_driver.md
PREDICTOR_MVMULT_ROW_DRIVER -- requirements
Module: predictor_mvmult_row_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32, max cycles from core start handshake to core done before abort.
REQ-002 SHALL have parameter DATA_W, default 64, width of sample and result words.
REQ-003 SHALL have port ap_clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port ap_rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports x_tdata in DATA_W, x_tvalid in 1, x_tready out 1  signed input sample stream.
REQ-006 SHALL have ports core_ap_start out 1, core_ap_ready in 1, core_ap_done in 1, core_ap_idle in 1  ap_ctrl_hs master toward the row-multiply core.
REQ-007 SHALL have port core_x  out  DATA_W  operand to core, held stable from START until return to IDLE.
REQ-008 SHALL have ports core_y0/core_y1 in DATA_W, core_y0_vld/core_y1_vld in 1  core result words with one-cycle valid strobes.
REQ-009 SHALL have ports y_tdata out DATA_W, y_tvalid out 1, y_tready in 1, y_tlast out 1  result output stream.
REQ-010 SHALL have ports busy out 1, err_timeout out 1 (sticky), err_clr in 1.

Function
REQ-011 FSM states SHALL be IDLE, START, WAIT, OUT0, OUT1.
REQ-012 x_tready SHALL be 1 only in IDLE with err_timeout=0; on x_tvalid&x_tready, x_tdata SHALL latch into core_x and FSM SHALL go to START.
REQ-013 In START core_ap_start SHALL be 1; on a cycle with core_ap_ready=1, FSM SHALL go to WAIT and core_ap_start SHALL drop next cycle.
REQ-014 In WAIT, core_y0 SHALL be captured on core_y0_vld and core_y1 on core_y1_vld; last strobe wins if repeated.
REQ-015 Strobes arriving in the same cycle as core_ap_done SHALL be captured and count as received.
REQ-016 On core_ap_done with both words received, FSM SHALL go to OUT0; both flags SHALL clear on entry to START.
REQ-017 On core_ap_done with a word missing, the missing word SHALL output as 0; FSM still goes to OUT0.
REQ-018 A cycle counter SHALL reset on entry to START and increment in START/WAIT; reaching TIMEOUT_CYCLES SHALL set err_timeout, deassert core_ap_start and return to IDLE with no output.
REQ-019 OUT0 SHALL drive y_tvalid=1, y_tdata=captured y0, y_tlast=0; OUT1 SHALL drive y_tdata=captured y1, y_tlast=1.
REQ-020 OUT0->OUT1 and OUT1->IDLE SHALL occur only on y_tvalid&y_tready; y_tdata/y_tlast SHALL stay stable while y_tvalid=1 and y_tready=0.
REQ-021 busy SHALL be 1 in every state except IDLE.
REQ-022 err_clr SHALL clear err_timeout next cycle; if err_clr coincides with a timeout event, set SHALL win.
REQ-023 Result latency: first y_tvalid SHALL rise exactly one cycle after the cycle core_ap_done=1 is sampled in WAIT.
REQ-024 core_ap_idle SHALL be ignored for control; it is observed only for assertions.

Reset
REQ-025 On ap_rst_n=0, FSM SHALL enter IDLE asynchronously; core_ap_start, y_tvalid, y_tlast, busy, err_timeout, received flags, counter SHALL be 0; core_x, captured words SHALL be 0.
REQ-026 Reset mid-transaction SHALL abandon it with no output; first post-reset x_tvalid SHALL start a fresh transaction.

Structure
REQ-027 FSM state encoding, DATA_W default and TIMEOUT_CYCLES default SHALL reside in the shared predictor package.
REQ-028 One sub-module, predictor_result_capture, SHALL hold the two capture registers and received flags; counter and FSM stay in the top.

Verification
REQ-029 Behavioural core model (5-cycle latency, y0=(190532990*x)>>>32, y1=(95724*x)>>>32); x=0x0000_0001_0000_0000 -> y0=190532990 then y1=95724 with tlast=1.
REQ-030 y_tready held 0 for 10 cycles in OUT0 -> y_tdata=y0 stable, no state change; tready=1 -> two beats in two cycles.
REQ-031 Core model never asserts done, TIMEOUT_CYCLES=32 -> err_timeout=1 at cycle 32 after START, x_tready=0 until err_clr pulse.
REQ-032 Both vld strobes and done in same cycle, x=-0x0000_0001_0000_0000 -> y0=-190532990, y1=-95724.
REQ-033 Only y1 strobed before done -> output y0=0, y1=95724 for x=0x0000_0001_0000_0000.
REQ-034 ap_rst_n pulsed low during WAIT -> all outputs 0 immediately, no y_tvalid; next sample completes normally.
